// File: rtl/gemm_ctrl_pkg.sv
// Shared types for the GeMM tiling loop controller: FSM states and outer-loop order.
package gemm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } ctrl_state_t;

  typedef enum logic {
    LoopMNK = 1'b0,
    LoopNMK = 1'b1
  } loop_order_t;

endpackage

// File: rtl/gemm_block_counter.sv
// Wrapping block counter: counts 0..ceiling-1 on tick, flags the last index.
module gemm_block_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             clear_i,
  input  logic [Width-1:0] ceiling_i,
  output logic [Width-1:0] count_o,
  output logic             last_o
);

  logic [Width-1:0] count_q, count_d;

  assign last_o  = (count_q == ceiling_i - Width'(1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = last_o ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gemm_loop_controller.sv
// GeMM tiling loop controller: walks M/N/K block loops (K innermost) with selectable outer order.
// Optional performance counters are built when GEMM_CTRL_PERF_EN is defined.
module gemm_loop_controller
  import gemm_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth = 16
`ifdef GEMM_CTRL_PERF_EN
  , parameter int unsigned PerfWidth = 32
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 loop_order_i,
  input  logic [AddrWidth-1:0] M_size_i,
  input  logic [AddrWidth-1:0] K_size_i,
  input  logic [AddrWidth-1:0] N_size_i,
  input  logic                 input_valid_i,
  output logic                 input_ready_o,
  output logic                 init_save_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [AddrWidth-1:0] res_m_o,
  output logic [AddrWidth-1:0] res_n_o,
  output logic [AddrWidth-1:0] M_count_o,
  output logic [AddrWidth-1:0] K_count_o,
  output logic [AddrWidth-1:0] N_count_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
`ifdef GEMM_CTRL_PERF_EN
  , output logic [PerfWidth-1:0] perf_busy_cycles_o,
  output logic [PerfWidth-1:0] perf_stall_cycles_o
`endif
);

  ctrl_state_t state_q, state_d;
  loop_order_t order_q, order_d;
  logic [AddrWidth-1:0] m_size_q, m_size_d, k_size_q, k_size_d, n_size_q, n_size_d;
  logic [AddrWidth-1:0] res_m_q, res_m_d, res_n_q, res_n_d;
  logic res_valid_q, res_valid_d;
  logic error_q, error_d;

  logic beat, start_ok, clear;
  logic m_tick, n_tick, mid_tick, outer_tick;
  logic m_last, k_last, n_last, mid_last, outer_last, job_last;
  logic [AddrWidth-1:0] m_count, k_count, n_count;

  assign start_ok = (state_q == IDLE) && start_i &&
                    (M_size_i != '0) && (K_size_i != '0) && (N_size_i != '0);
  assign clear    = start_ok || (state_q == FINISH);

  // The one-entry result slot can be refilled in the same cycle it is accepted.
  assign input_ready_o = (state_q == BUSY) && (!res_valid_q || result_ready_i);
  assign beat          = input_valid_i && input_ready_o;
  assign init_save_o   = beat && (k_count == '0);

  assign mid_last   = (order_q == LoopMNK) ? n_last : m_last;
  assign outer_last = (order_q == LoopMNK) ? m_last : n_last;
  assign mid_tick   = beat && k_last;
  assign outer_tick = mid_tick && mid_last;
  assign job_last   = outer_tick && outer_last;
  assign m_tick     = (order_q == LoopMNK) ? outer_tick : mid_tick;
  assign n_tick     = (order_q == LoopMNK) ? mid_tick : outer_tick;

  gemm_block_counter #(.Width(AddrWidth)) u_m_counter (
    .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(m_tick), .clear_i(clear),
    .ceiling_i(m_size_q), .count_o(m_count), .last_o(m_last)
  );

  gemm_block_counter #(.Width(AddrWidth)) u_k_counter (
    .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(beat), .clear_i(clear),
    .ceiling_i(k_size_q), .count_o(k_count), .last_o(k_last)
  );

  gemm_block_counter #(.Width(AddrWidth)) u_n_counter (
    .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(n_tick), .clear_i(clear),
    .ceiling_i(n_size_q), .count_o(n_count), .last_o(n_last)
  );

  always_comb begin
    state_d     = state_q;
    order_d     = order_q;
    m_size_d    = m_size_q;
    k_size_d    = k_size_q;
    n_size_d    = n_size_q;
    error_d     = 1'b0;
    res_valid_d = res_valid_q;
    res_m_d     = res_m_q;
    res_n_d     = res_n_q;

    if (result_ready_i) begin
      res_valid_d = 1'b0;
    end
    if (mid_tick) begin
      res_valid_d = 1'b1;
      res_m_d     = m_count;
      res_n_d     = n_count;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (start_ok) begin
            order_d  = loop_order_t'(loop_order_i);
            m_size_d = M_size_i;
            k_size_d = K_size_i;
            n_size_d = N_size_i;
            state_d  = BUSY;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (job_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (!res_valid_q || result_ready_i) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      order_q     <= LoopMNK;
      m_size_q    <= '0;
      k_size_q    <= '0;
      n_size_q    <= '0;
      error_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_m_q     <= '0;
      res_n_q     <= '0;
    end else begin
      state_q     <= state_d;
      order_q     <= order_d;
      m_size_q    <= m_size_d;
      k_size_q    <= k_size_d;
      n_size_q    <= n_size_d;
      error_q     <= error_d;
      res_valid_q <= res_valid_d;
      res_m_q     <= res_m_d;
      res_n_q     <= res_n_d;
    end
  end

  assign result_valid_o = res_valid_q;
  assign res_m_o        = res_m_q;
  assign res_n_o        = res_n_q;
  assign M_count_o      = m_count;
  assign K_count_o      = k_count;
  assign N_count_o      = n_count;
  assign busy_o         = (state_q == BUSY) || (state_q == DRAIN);
  assign done_o         = (state_q == FINISH);
  assign error_o        = error_q;

`ifdef GEMM_CTRL_PERF_EN
  logic [PerfWidth-1:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;

  // Saturating counters, restarted on each accepted job and frozen once idle.
  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (start_ok) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (busy_o && (perf_busy_q != '1)) perf_busy_d = perf_busy_q + PerfWidth'(1);
      if ((state_q == BUSY) && input_valid_i && !input_ready_o && (perf_stall_q != '1))
        perf_stall_d = perf_stall_q + PerfWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cycles_o  = perf_busy_q;
  assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_gemm_loop_controller.sv
// Directed self-checking bench for gemm_loop_controller (perf checks when GEMM_CTRL_PERF_EN is defined).
module tb_gemm_loop_controller;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        loop_order_i = 1'b0;
  logic [15:0] M_size_i = '0, K_size_i = '0, N_size_i = '0;
  logic        input_valid_i = 1'b0;
  logic        result_ready_i = 1'b1;
  logic        input_ready_o, init_save_o, result_valid_o;
  logic [15:0] res_m_o, res_n_o, M_count_o, K_count_o, N_count_o;
  logic        busy_o, done_o, error_o;
`ifdef GEMM_CTRL_PERF_EN
  logic [31:0] perf_busy_cycles_o, perf_stall_cycles_o;
`endif

  gemm_loop_controller dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .loop_order_i(loop_order_i),
    .M_size_i(M_size_i), .K_size_i(K_size_i), .N_size_i(N_size_i),
    .input_valid_i(input_valid_i), .input_ready_o(input_ready_o), .init_save_o(init_save_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .res_m_o(res_m_o), .res_n_o(res_n_o),
    .M_count_o(M_count_o), .K_count_o(K_count_o), .N_count_o(N_count_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
`ifdef GEMM_CTRL_PERF_EN
    , .perf_busy_cycles_o(perf_busy_cycles_o), .perf_stall_cycles_o(perf_stall_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  int          beats, doneCount, stalledCycles, violations;
  logic [31:0] initMask;
  logic        timedOut;
  logic [7:0]  tagQ[$];

  // Drives one job and records beats, init_save positions, accepted tags and done pulses.
  task automatic run_job(input logic ord, input logic [15:0] m, input logic [15:0] k,
                         input logic [15:0] n, input int validMode, input int stallCycles,
                         input int abortBeats);
    int stallLeft;
    logic finished, aborted, haveHeld;
    logic [7:0] heldTag;
    beats = 0; doneCount = 0; stalledCycles = 0; violations = 0; initMask = '0;
    tagQ.delete();
    finished = 1'b0; aborted = 1'b0; haveHeld = 1'b0; heldTag = '0;
    stallLeft = stallCycles;
    @(posedge clk_i); #1;
    loop_order_i = ord; M_size_i = m; K_size_i = k; N_size_i = n;
    start_i = 1'b1; input_valid_i = 1'b0; result_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    loop_order_i = ~ord; M_size_i = 16'd7; K_size_i = 16'd7; N_size_i = 16'd7;
    for (int cyc = 0; cyc < 300; cyc++) begin
      input_valid_i  = (validMode == 1) ? (cyc % 2 == 0) : 1'b1;
      result_ready_i = (stallLeft == 0);
      @(negedge clk_i);
      if (input_valid_i && input_ready_o) begin
        if (init_save_o) initMask[beats] = 1'b1;
        beats++;
      end
      if (result_valid_o) begin
        if (result_ready_i) begin
          tagQ.push_back({res_m_o[3:0], res_n_o[3:0]});
        end else begin
          if (!haveHeld) begin
            heldTag  = {res_m_o[3:0], res_n_o[3:0]};
            haveHeld = 1'b1;
          end
          if (input_ready_o !== 1'b0 || {res_m_o[3:0], res_n_o[3:0]} !== heldTag) violations++;
          stalledCycles++;
          stallLeft--;
        end
      end
      if (done_o) begin
        doneCount++;
        finished = 1'b1;
      end
      if (abortBeats != 0 && beats == abortBeats) aborted = 1'b1;
      if (finished || aborted) break;
      @(posedge clk_i); #1;
    end
    input_valid_i  = 1'b0;
    result_ready_i = 1'b1;
    timedOut = !finished && !aborted;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    input_valid_i = 1'b1;
    start_i = 1'b1; M_size_i = 16'd2; K_size_i = 16'd2; N_size_i = 16'd2;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({input_ready_o, init_save_o, result_valid_o, res_m_o, res_n_o, M_count_o,
         K_count_o, N_count_o, busy_o, done_o, error_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: some output nonzero in reset (busy=%b ready=%b)",
               busy_o, input_ready_o);
    end
    start_i = 1'b0; input_valid_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_busy: got %b want 0", busy_o);
    end
  endtask

  task automatic test_order(input logic ord, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp4[4];
    exp4 = '{e0, e1, e2, e3};
    run_job(ord, 16'd2, 16'd3, 16'd2, 0, 0, 0);
    checks++;
    if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL order%0d_timeout: got %b want 0", ord, timedOut); end
    checks++;
    if (beats != 12) begin errors++; $display("[TB] FAIL order%0d_beats: got %0d want 12", ord, beats); end
    checks++;
    if (initMask !== 32'h249) begin errors++; $display("[TB] FAIL order%0d_init_save: got %h want 249", ord, initMask); end
    checks++;
    if (tagQ.size() != 4) begin
      errors++; $display("[TB] FAIL order%0d_result_count: got %0d want 4", ord, tagQ.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tagQ[i] !== exp4[i]) begin
          errors++; $display("[TB] FAIL order%0d_tag%0d: got %h want %h", ord, i, tagQ[i], exp4[i]);
        end
      end
    end
    checks++;
    if (doneCount != 1) begin errors++; $display("[TB] FAIL order%0d_done: got %0d want 1", ord, doneCount); end
    @(negedge clk_i);
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin
      errors++; $display("[TB] FAIL order%0d_after_done: got done=%b busy=%b want 0 0", ord, done_o, busy_o);
    end
  endtask

  task automatic test_backpressure;
    run_job(1'b0, 16'd2, 16'd1, 16'd2, 0, 5, 0);
    checks++;
    if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL bp_timeout: got %b want 0", timedOut); end
    checks++;
    if (stalledCycles != 5) begin errors++; $display("[TB] FAIL bp_stalled: got %0d want 5", stalledCycles); end
    checks++;
    if (violations != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d violations want 0", violations); end
    checks++;
    if (initMask !== 32'hF) begin errors++; $display("[TB] FAIL bp_init_save: got %h want f", initMask); end
    checks++;
    if (tagQ.size() != 4) begin
      errors++; $display("[TB] FAIL bp_result_count: got %0d want 4", tagQ.size());
    end else begin
      checks++;
      if ({tagQ[0], tagQ[1], tagQ[2], tagQ[3]} !== 32'h00011011) begin
        errors++; $display("[TB] FAIL bp_tags: got %h%h%h%h want 00011011", tagQ[0], tagQ[1], tagQ[2], tagQ[3]);
      end
    end
  endtask

  task automatic test_zero_size;
    @(posedge clk_i); #1;
    M_size_i = 16'd2; K_size_i = 16'd2; N_size_i = 16'd0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({error_o, busy_o} !== 2'b10) begin
      errors++; $display("[TB] FAIL zero_error_pulse: got error=%b busy=%b want 1 0", error_o, busy_o);
    end
    checks++;
    if ({M_count_o, K_count_o, N_count_o} !== '0) begin
      errors++; $display("[TB] FAIL zero_counters: got %0d %0d %0d want 0", M_count_o, K_count_o, N_count_o);
    end
    @(negedge clk_i);
    checks++;
    if ({error_o, busy_o} !== 2'b00) begin
      errors++; $display("[TB] FAIL zero_error_end: got error=%b busy=%b want 0 0", error_o, busy_o);
    end
  endtask

  task automatic test_back_to_back;
    run_job(1'b0, 16'd1, 16'd1, 16'd1, 0, 0, 0);
    checks++;
    if ({timedOut, beats[3:0], doneCount[3:0], initMask[3:0]} !== {1'b0, 4'd1, 4'd1, 4'h1}) begin
      errors++; $display("[TB] FAIL b2b_job: got to=%b beats=%0d done=%0d init=%h want 0 1 1 1",
                         timedOut, beats, doneCount, initMask);
    end
    checks++;
    if (tagQ.size() != 1) begin
      errors++; $display("[TB] FAIL b2b_results: got %0d want 1", tagQ.size());
    end
  endtask

  task automatic test_reset_mid_job;
    run_job(1'b0, 16'd2, 16'd3, 16'd2, 0, 0, 5);
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({input_ready_o, init_save_o, result_valid_o, res_m_o, res_n_o, M_count_o,
         K_count_o, N_count_o, busy_o, done_o, error_o} !== '0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got busy=%b k=%0d valid=%b want all 0",
                         busy_o, K_count_o, result_valid_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_job(1'b0, 16'd2, 16'd3, 16'd2, 0, 0, 0);
    checks++;
    if ({timedOut, beats[4:0], doneCount[1:0]} !== {1'b0, 5'd12, 2'd1}) begin
      errors++; $display("[TB] FAIL midreset_rerun: got to=%b beats=%0d done=%0d want 0 12 1",
                         timedOut, beats, doneCount);
    end
    checks++;
    if (tagQ.size() != 4) begin
      errors++; $display("[TB] FAIL midreset_results: got %0d want 4", tagQ.size());
    end
  endtask

`ifdef GEMM_CTRL_PERF_EN
  task automatic test_perf;
    logic [31:0] busySnap;
    run_job(1'b0, 16'd2, 16'd3, 16'd2, 1, 0, 0);
    checks++;
    if (beats != 12) begin errors++; $display("[TB] FAIL perf_beats: got %0d want 12", beats); end
    checks++;
    if (perf_stall_cycles_o !== 32'd0) begin
      errors++; $display("[TB] FAIL perf_stall: got %0d want 0", perf_stall_cycles_o);
    end
    checks++;
    if (perf_busy_cycles_o < 32'd24) begin
      errors++; $display("[TB] FAIL perf_busy: got %0d want >= 24", perf_busy_cycles_o);
    end
    busySnap = perf_busy_cycles_o;
    repeat (3) @(negedge clk_i);
    checks++;
    if (perf_busy_cycles_o !== busySnap) begin
      errors++; $display("[TB] FAIL perf_hold: got %0d want %0d", perf_busy_cycles_o, busySnap);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_order(1'b0, 8'h00, 8'h01, 8'h10, 8'h11);
    test_order(1'b1, 8'h00, 8'h10, 8'h01, 8'h11);
    test_backpressure();
    test_zero_size();
    test_back_to_back();
    test_reset_mid_job();
`ifdef GEMM_CTRL_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
